// File: rtl/spi_xfer_sequencer_pkg.sv
// Shared definitions for the SPI transfer sequencer.
//   seqState_t    : sequencer FSM encoding (6 states, 3 bits)
//   STATUS_BF_BIT : default bit position of the busy flag in the SPI status byte
package spi_xfer_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_SET = 3'd2,
    WAIT_CLR = 3'd3,
    READ     = 3'd4,
    STORE    = 3'd5
  } seqState_t;

  localparam int STATUS_BF_BIT = 0;

endpackage

// File: rtl/spi_xfer_sequencer_if.sv
// Connection between the sequencer and the SPI master peripheral.
//   statREAD : status read strobe          (sequencer -> peripheral)
//   statOUT  : status byte                 (peripheral -> sequencer)
//   wrBUF    : buffer write strobe         (sequencer -> peripheral)
//   bufIN    : byte written with wrBUF     (sequencer -> peripheral)
//   rdBUF    : buffer read strobe          (sequencer -> peripheral)
//   bufOUT   : receive buffer contents     (peripheral -> sequencer)
interface spi_xfer_sequencer_if;

  logic       statREAD;
  logic [7:0] statOUT;
  logic       wrBUF;
  logic [7:0] bufIN;
  logic       rdBUF;
  logic [7:0] bufOUT;

  modport master (
    output statREAD, wrBUF, bufIN, rdBUF,
    input  statOUT, bufOUT
  );

  modport slave (
    input  statREAD, wrBUF, bufIN, rdBUF,
    output statOUT, bufOUT
  );

endinterface

// File: rtl/spi_xfer_sequencer_fifo.sv
// spi_byte_fifo: synchronous byte FIFO with first-word fall-through read port.
//   push/pushData : write side; a push while full is accepted only with a pop
//   pop/popData   : read side; popData shows the head, pop while empty is ignored
//   full/empty    : occupancy flags
//   count         : occupancy, AW+1 bits so full is count == DEPTH
// Storage is not reset; only pointers and count are.
module spi_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    pushData,
  input  logic          pop,
  output logic [7:0]    popData,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          popOk;
  logic          pushOk;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign popOk   = pop && !empty;
  assign pushOk  = push && (!full || popOk);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: streams bytes from a TX FIFO through the SPI master
// peripheral and collects the received bytes into an RX FIFO.
//   tx_data/tx_wr/tx_full/tx_count : processor side of the TX FIFO
//   rx_data/rx_rd/rx_empty/rx_count: processor side of the RX FIFO (FWFT)
//   err_clr/tx_ovf/rx_ovf          : sticky overflow flags and their clear
//   busy                           : sequencer is working on a byte
//   spi                            : registered strobes to the SPI peripheral
// Per byte: IDLE pops the TX head, LOAD pulses wrBUF, WAIT_SET polls until
// busy rises (or times out), WAIT_CLR polls until busy falls, READ pulses
// rdBUF and STORE pushes the captured byte into the RX FIFO.
module spi_xfer_sequencer
  import spi_xfer_sequencer_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int BF_BIT      = STATUS_BF_BIT,
  parameter int SET_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    tx_data,
  input  logic          tx_wr,
  output logic          tx_full,
  output logic [AW:0]   tx_count,
  output logic [7:0]    rx_data,
  input  logic          rx_rd,
  output logic          rx_empty,
  output logic [AW:0]   rx_count,
  input  logic          err_clr,
  output logic          tx_ovf,
  output logic          rx_ovf,
  output logic          busy,
  spi_xfer_sequencer_if.master spi
);

  localparam int CW = $clog2(SET_TIMEOUT + 1);

  seqState_t     state;
  seqState_t     stateNext;
  logic [CW-1:0] toCnt;
  logic [CW-1:0] toCntNext;
  logic          txPop;
  logic          txEmpty;
  logic [7:0]    txHead;
  logic          rxPush;
  logic          rxFull;
  logic [7:0]    rxByte;
  logic          txOvfEvt;
  logic          rxOvfEvt;
  logic          bfSample;

  spi_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) txFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tx_wr),
    .pushData (tx_data),
    .pop      (txPop),
    .popData  (txHead),
    .full     (tx_full),
    .empty    (txEmpty),
    .count    (tx_count)
  );

  spi_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) rxFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rxPush),
    .pushData (rxByte),
    .pop      (rx_rd),
    .popData  (rx_data),
    .full     (rxFull),
    .empty    (rx_empty),
    .count    (rx_count)
  );

  assign busy     = (state != IDLE);
  assign bfSample = spi.statOUT[BF_BIT];
  assign rxPush   = (state == STORE);
  // A push onto a full FIFO is only lost when nothing leaves in the same cycle.
  assign txOvfEvt = tx_wr && tx_full && !txPop;
  assign rxOvfEvt = rxPush && rxFull && !rx_rd;

  always_comb begin
    stateNext = state;
    toCntNext = toCnt;
    txPop     = 1'b0;
    case (state)
      IDLE: begin
        if (!txEmpty) begin
          txPop     = 1'b1;
          stateNext = LOAD;
        end
      end
      LOAD: begin
        toCntNext = '0;
        stateNext = WAIT_SET;
      end
      WAIT_SET: begin
        // Timeout covers transfers that finish before the first poll.
        if (bfSample)                             stateNext = WAIT_CLR;
        else if (toCnt == CW'(SET_TIMEOUT - 1))   stateNext = READ;
        else                                      toCntNext = toCnt + 1'b1;
      end
      WAIT_CLR: begin
        if (!bfSample) stateNext = READ;
      end
      READ:    stateNext = STORE;
      STORE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high exactly while
  // the FSM sits in the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      toCnt        <= '0;
      spi.statREAD <= 1'b0;
      spi.wrBUF    <= 1'b0;
      spi.rdBUF    <= 1'b0;
      spi.bufIN    <= 8'h00;
      tx_ovf       <= 1'b0;
      rx_ovf       <= 1'b0;
    end else begin
      state        <= stateNext;
      toCnt        <= toCntNext;
      spi.wrBUF    <= (stateNext == LOAD);
      spi.statREAD <= (stateNext == WAIT_SET) || (stateNext == WAIT_CLR);
      spi.rdBUF    <= (stateNext == READ);
      if (txPop) spi.bufIN <= txHead;
      // Set event beats a simultaneous clear.
      if (txOvfEvt)     tx_ovf <= 1'b1;
      else if (err_clr) tx_ovf <= 1'b0;
      if (rxOvfEvt)     rx_ovf <= 1'b1;
      else if (err_clr) rx_ovf <= 1'b0;
    end
  end

  // Received byte captured at the edge that ends the rdBUF cycle.
  always_ff @(posedge clk) begin
    if (state == READ) rxByte <= spi.bufOUT;
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed testbench for spi_xfer_sequencer with a small SPI peripheral model.
// The model raises the busy flag for bfLen cycles after each wrBUF (0 = never)
// and returns the written byte XOR 0x99 as the received byte.
module tb_spi_xfer_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic [3:0] tx_count;
  logic [7:0] rx_data;
  logic       rx_rd;
  logic       rx_empty;
  logic [3:0] rx_count;
  logic       err_clr;
  logic       tx_ovf;
  logic       rx_ovf;
  logic       busy;

  spi_xfer_sequencer_if spiBus ();

  spi_xfer_sequencer #(.DEPTH(8), .AW(3), .BF_BIT(0), .SET_TIMEOUT(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_full  (tx_full),
    .tx_count (tx_count),
    .rx_data  (rx_data),
    .rx_rd    (rx_rd),
    .rx_empty (rx_empty),
    .rx_count (rx_count),
    .err_clr  (err_clr),
    .tx_ovf   (tx_ovf),
    .rx_ovf   (rx_ovf),
    .busy     (busy),
    .spi      (spiBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral model
  int         bfLen;
  int         busyLeft;
  int         wrCnt;
  int         rdCnt;
  int         stCnt;
  logic [7:0] rxModel;
  logic [7:0] txLog [$];

  assign spiBus.statOUT = {7'b0, (busyLeft != 0)};
  assign spiBus.bufOUT  = rxModel;

  initial begin
    busyLeft = 0;
    wrCnt    = 0;
    rdCnt    = 0;
    stCnt    = 0;
    rxModel  = 8'h00;
  end

  always @(posedge clk) begin
    if (reset) begin
      busyLeft <= 0;
    end else if (spiBus.wrBUF) begin
      busyLeft <= bfLen;
      rxModel  <= spiBus.bufIN ^ 8'h99;
      wrCnt    <= wrCnt + 1;
      txLog.push_back(spiBus.bufIN);
    end else if (busyLeft > 0) begin
      busyLeft <= busyLeft - 1;
    end
    if (!reset && spiBus.rdBUF)    rdCnt <= rdCnt + 1;
    if (!reset && spiBus.statREAD) stCnt <= stCnt + 1;
  end

  int checks;
  int errors;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] b);
    tx_data = b;
    tx_wr   = 1'b1;
    tick();
    tx_wr   = 1'b0;
  endtask

  task automatic popRx();
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || tx_count != 0) && n < budget) begin
      tick();
      n++;
    end
    checkEq({tag, "_done"}, {31'b0, (busy == 1'b0 && tx_count == 0)}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] expRx [8];
    logic [7:0] expLog [9];
    int s0;
    int r0;
    int n;
    int logBase;

    checks  = 0;
    errors  = 0;
    tx_data = 8'h00;
    tx_wr   = 1'b0;
    rx_rd   = 1'b0;
    err_clr = 1'b0;
    bfLen   = 8;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkEq("rst_busy",     busy,            0);
    checkEq("rst_txCount",  tx_count,        0);
    checkEq("rst_rxEmpty",  rx_empty,        1);
    checkEq("rst_rxCount",  rx_count,        0);
    checkEq("rst_txOvf",    tx_ovf,          0);
    checkEq("rst_rxOvf",    rx_ovf,          0);
    checkEq("rst_wrBUF",    spiBus.wrBUF,    0);
    checkEq("rst_rdBUF",    spiBus.rdBUF,    0);
    checkEq("rst_statREAD", spiBus.statREAD, 0);
    checkEq("rst_bufIN",    spiBus.bufIN,    8'h00);

    // Single byte, BF held for 8 cycles
    pushByte(8'hA5);
    tick();
    checkEq("t1_wrBUF",  spiBus.wrBUF, 1);
    checkEq("t1_bufIN",  spiBus.bufIN, 8'hA5);
    checkEq("t1_busy",   busy,         1);
    tick();
    checkEq("t1_wrPulse", spiBus.wrBUF,    0);
    checkEq("t1_statRd",  spiBus.statREAD, 1);
    waitDone("t1", 60);
    checkEq("t1_wrCnt",   wrCnt,    1);
    checkEq("t1_rdCnt",   rdCnt,    1);
    checkEq("t1_rxCount", rx_count, 1);
    checkEq("t1_rxData",  rx_data,  8'h3C);
    popRx();
    checkEq("t1_rxEmpty", rx_empty, 1);

    // Minimum transfer: busy for 5 cycles (LOAD..STORE)
    bfLen = 1;
    pushByte(8'h42);
    tick();
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    checkEq("min_busyCycles", n, 5);
    checkEq("min_rxData", rx_data, 8'hDB);
    popRx();

    // TX fill/overflow and RX overflow
    logBase = txLog.size();
    bfLen = 30;
    pushByte(8'hF0);
    for (int i = 1; i <= 8; i++) pushByte(8'(i));
    checkEq("t2_txFull",  tx_full,  1);
    checkEq("t2_txCount", tx_count, 8);
    checkEq("t2_txOvf0",  tx_ovf,   0);
    pushByte(8'h09);
    checkEq("t2_txOvf",   tx_ovf,   1);
    checkEq("t2_txCount9", tx_count, 8);
    err_clr = 1'b1;
    pushByte(8'h0A);
    err_clr = 1'b0;
    checkEq("t2_setWins", tx_ovf, 1);
    bfLen = 3;
    waitDone("t2", 500);
    expLog = '{8'hF0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    checkEq("t2_logSize", txLog.size() - logBase, 9);
    for (int i = 0; i < 9; i++)
      if (logBase + i < txLog.size())
        checkEq($sformatf("t2_bufIN%0d", i), txLog[logBase + i], expLog[i]);
    checkEq("t3_rxCount", rx_count, 8);
    checkEq("t3_rxOvf",   rx_ovf,   1);
    checkEq("t3_rxHead",  rx_data,  8'h69);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkEq("t3_rxOvfClr", rx_ovf, 0);
    checkEq("t3_txOvfClr", tx_ovf, 0);
    expRx = '{8'h69, 8'h98, 8'h9B, 8'h9A, 8'h9D, 8'h9C, 8'h9F, 8'h9E};
    for (int i = 0; i < 8; i++) begin
      checkEq($sformatf("t3_rx%0d", i), rx_data, expRx[i]);
      popRx();
    end
    checkEq("t3_rxEmpty", rx_empty, 1);

    // Busy flag never rises: 15 polls then read
    bfLen = 0;
    s0 = stCnt;
    r0 = rdCnt;
    pushByte(8'h5A);
    waitDone("t4", 60);
    checkEq("t4_polls",   stCnt - s0, 15);
    checkEq("t4_rdCnt",   rdCnt - r0, 1);
    checkEq("t4_rxCount", rx_count,   1);
    checkEq("t4_rxData",  rx_data,    8'hC3);
    checkEq("t4_busy",    busy,       0);
    popRx();

    // Reset during WAIT_CLR with 3 bytes queued
    bfLen = 30;
    pushByte(8'h10);
    pushByte(8'h11);
    pushByte(8'h22);
    pushByte(8'h33);
    for (int i = 0; i < 4; i++) tick();
    checkEq("t5_preCount", tx_count, 3);
    checkEq("t5_preBusy",  busy,     1);
    checkEq("t5_preStat",  spiBus.statREAD, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkEq("t5_txCount",  tx_count,        0);
    checkEq("t5_busy",     busy,            0);
    checkEq("t5_wrBUF",    spiBus.wrBUF,    0);
    checkEq("t5_rdBUF",    spiBus.rdBUF,    0);
    checkEq("t5_statREAD", spiBus.statREAD, 0);
    checkEq("t5_rxEmpty",  rx_empty,        1);
    bfLen = 2;
    pushByte(8'h77);
    waitDone("t5", 60);
    checkEq("t5_lastBufIN", txLog[txLog.size() - 1], 8'h77);
    checkEq("t5_rxCount",   rx_count, 1);
    checkEq("t5_rxData",    rx_data,  8'hEE);
    popRx();

    // rx_rd on empty, then rx_rd coinciding with STORE on a full RX FIFO
    popRx();
    checkEq("t6_emptyCount", rx_count, 0);
    checkEq("t6_emptyFlag",  rx_empty, 1);
    checkEq("t6_emptyOvf",   rx_ovf,   0);
    bfLen = 1;
    for (int i = 0; i < 8; i++) pushByte(8'h80 + 8'(i));
    waitDone("t6fill", 200);
    checkEq("t6_fullCount", rx_count, 8);
    checkEq("t6_fullHead",  rx_data,  8'h19);
    pushByte(8'h40);
    n = 0;
    while (spiBus.rdBUF !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checkEq("t6_rdSeen", spiBus.rdBUF, 1);
    tick();
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
    checkEq("t6_simCount", rx_count, 8);
    checkEq("t6_simOvf",   rx_ovf,   0);
    checkEq("t6_simHead",  rx_data,  8'h18);
    for (int i = 0; i < 7; i++) popRx();
    checkEq("t6_lastCount", rx_count, 1);
    checkEq("t6_lastData",  rx_data,  8'hD9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_sequencer.md
Name: spi_xfer_sequencer

Overview:
- Sits between the processor peripheral bus and the SPI master peripheral (control/status/buffer registers plus engine).
- Queues outgoing bytes in a TX FIFO and feeds each one to the SPI buffer via a wrBUF pulse.
- Polls the SPI status busy flag until the transfer completes, then reads the received byte back into an RX FIFO.
- Lets the processor stream multiple bytes without polling the SPI status itself.

Parameters:
- DEPTH, 8, entries in each of the TX and RX FIFOs (power of two, at least 2).
- AW, 3, log2(DEPTH).
- BF_BIT, 0, bit of the SPI statOUT that carries the busy flag.
- SET_TIMEOUT, 15, maximum cycles to wait for the busy flag to rise after wrBUF.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- tx_data  in  8  byte to transmit
- tx_wr  in  1  push tx_data into the TX FIFO
- tx_full  out  1  TX FIFO full
- tx_count  out  AW+1  TX FIFO occupancy
- rx_data  out  8  head of the RX FIFO (first-word fall-through)
- rx_rd  in  1  pop the RX FIFO
- rx_empty  out  1  RX FIFO empty
- rx_count  out  AW+1  RX FIFO occupancy
- err_clr  in  1  clear the sticky error flags
- tx_ovf  out  1  sticky: push attempted while TX FIFO full
- rx_ovf  out  1  sticky: received byte dropped because RX FIFO full
- busy  out  1  FSM not in IDLE
- spi_statREAD  out  1  status read strobe to the SPI peripheral
- spi_statOUT  in  8  SPI status byte
- spi_wrBUF  out  1  SPI buffer write strobe
- spi_bufIN  out  8  byte presented with spi_wrBUF
- spi_rdBUF  out  1  SPI buffer read strobe
- spi_bufOUT  in  8  SPI receive buffer contents

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high.
- Reset effects: both FIFOs empty, FSM in IDLE, all strobes 0, spi_bufIN 0, tx_ovf and rx_ovf 0, busy 0.
- Reset mid-transfer: abandons the byte in progress and does not wait on the SPI engine.
- All spi_* outputs are registered. Each strobe is a single-cycle pulse.
- spi_statOUT is sampled at the clock edge that ends a cycle in which spi_statREAD=1.
- spi_bufOUT is sampled at the clock edge that ends a cycle in which spi_rdBUF=1.
- FSM states:
  - IDLE: if the TX FIFO is not empty, pop the head into spi_bufIN and go to LOAD.
  - LOAD: spi_wrBUF=1 for one cycle, clear the timeout counter, go to WAIT_SET.
  - WAIT_SET: spi_statREAD=1 each cycle.
    - Sampled BF=1: go to WAIT_CLR.
    - Counter reaches SET_TIMEOUT: go to READ (handles transfers that finish before the first poll).
    - Otherwise increment the counter.
  - WAIT_CLR: spi_statREAD=1 each cycle. Sampled BF=0: go to READ. No timeout.
  - READ: spi_rdBUF=1 for one cycle, go to STORE.
  - STORE: push the sampled spi_bufOUT into the RX FIFO, go to IDLE.
    - If the RX FIFO is full and rx_rd is not asserted this cycle, drop the byte and set rx_ovf.
    - If rx_rd is asserted in the same cycle, pop and push together, with no loss.
- Minimum IDLE-to-IDLE time is 6 cycles. Back-to-back bytes restart from IDLE with no extra gap.
- TX FIFO:
  - tx_wr while full with no FSM pop in the same cycle: ignored, sets tx_ovf.
  - Simultaneous push and pop on a full FIFO is accepted.
  - Pointers wrap modulo DEPTH; count is kept in AW+1 bits, so full is count==DEPTH.
- RX FIFO:
  - rx_rd while empty: ignored, no flag.
  - rx_data is undefined when empty; a bench must not check it then.
- Error flags: err_clr clears them the next cycle. A set event in the same cycle as err_clr wins, so the flag stays 1.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package: FSM state encoding (6 states, 3 bits) and a STATUS_BF_BIT default constant.
- One natural sub-module, spi_byte_fifo (parameterised DEPTH/AW, sync push/pop, count/full/empty), instantiated twice for TX and RX.
- The FSM and strobe registers live in the top.

Test Plan:
- Reset, then push 0xA5 with a model that holds BF=1 for 8 cycles after wrBUF → spi_wrBUF pulses once with spi_bufIN=0xA5. After BF drops, one spi_rdBUF pulse; model spi_bufOUT=0x3C gives rx_count=1 and rx_data=0x3C.
- Push 0x01..0x08 back-to-back → tx_full=1 after the 8th. A 9th push sets tx_ovf=1. All 8 bytes appear on spi_bufIN in order and 8 RX bytes are stored.
- Let the RX FIFO fill to 8 without rx_rd, then complete one more transfer → rx_ovf=1, rx_count stays 8, the oldest byte is still at rx_data. Then err_clr → rx_ovf=0.
- Model never raises BF → after 15 WAIT_SET cycles the FSM proceeds to READ/STORE and the byte is stored. busy returns to 0.
- Assert reset during WAIT_CLR with 3 bytes queued → next cycle tx_count=0, busy=0, all strobes 0. A later push of 0x77 transfers normally.
- rx_rd on empty and simultaneous rx_rd with STORE on a full RX FIFO → no count change and no flag on empty. The full case pops and pushes with rx_count held at 8 and rx_ovf=0.
